// File: rtl/kmeans_assign_param_if.sv
// kmeans_assign_param_if: word-in / result-out stream bundle for the K-means assignment engine.
interface kmeans_assign_param_if #(
    parameter int DW     = 32,
    parameter int IDX_W  = 2,
    parameter int DIST_W = 65
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DW-1:0]     IN_DATA;
    logic              IN_LAST;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [IDX_W-1:0]  OUT_DATA;
    logic [DIST_W-1:0] OUT_DIST;
    logic              ERR;
    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_DIST, ERR
    );
    modport master (
        output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_DIST, ERR
    );
endinterface

// File: rtl/kmeans_assign_param.sv
// kmeans_assign_param: loads K centroids, then streams points and emits nearest index and exact squared distance.
module kmeans_assign_param #(
    parameter int K   = 3,
    parameter int DIM = 2,
    parameter int DW  = 32
) (
    input logic                   CLK,
    input logic                   RESET,
    kmeans_assign_param_if.slave  bus
);
    localparam int IDX_W  = $clog2(K);
    localparam int DIST_W = 2 * DW + $clog2(DIM);
    localparam int DC_W   = DIM > 1 ? $clog2(DIM) : 1;
    localparam logic [0:0] S_LOAD  = 1'b0;
    localparam logic [0:0] S_POINT = 1'b1;

    logic [0:0]        r_state;
    logic [DC_W-1:0]   r_dcnt;
    logic [IDX_W-1:0]  r_kcnt;
    logic [DW-1:0]     r_cent [K][DIM];
    logic [DW-1:0]     r_diff [K];
    logic              r_s0_v, r_s0_first, r_s0_last, r_s1_v;
    logic [DIST_W-1:0] r_acc [K];
    logic              r_out_v, r_err;
    logic [IDX_W-1:0]  r_out_idx;
    logic [DIST_W-1:0] r_out_dist;
    logic              w_stall, w_acc, w_dlast, w_kend, w_err;
    logic [DW-1:0]     w_diff [K];
    logic [2*DW-1:0]   w_sq [K];
    logic [IDX_W-1:0]  w_best_i;
    logic [DIST_W-1:0] w_best_d;

    assign w_stall       = r_out_v & !bus.OUT_READY;
    assign bus.IN_READY  = !RESET & !w_stall;
    assign w_acc         = bus.IN_VALID & bus.IN_READY;
    assign w_dlast       = r_dcnt == DC_W'(DIM - 1);
    assign w_kend        = r_kcnt == IDX_W'(K - 1);
    // IN_LAST is legal only on the final centroid word or on a point's last coordinate
    assign w_err         = w_acc & bus.IN_LAST & (r_state == S_LOAD ? !(w_dlast & w_kend) : !w_dlast);
    assign bus.OUT_VALID = r_out_v;
    assign bus.OUT_DATA  = r_out_idx;
    assign bus.OUT_DIST  = r_out_dist;
    assign bus.ERR       = r_err;

    always_comb begin
        for (int k = 0; k < K; k++) begin
            w_diff[k] = bus.IN_DATA >= r_cent[k][r_dcnt] ? bus.IN_DATA - r_cent[k][r_dcnt]
                                                         : r_cent[k][r_dcnt] - bus.IN_DATA;
            w_sq[k]   = {DW'(0), r_diff[k]} * {DW'(0), r_diff[k]};
        end
    end

    // strict less-than keeps the lowest index on ties
    always_comb begin
        w_best_i = '0;
        w_best_d = r_acc[0];
        for (int k = 1; k < K; k++) begin
            if (r_acc[k] < w_best_d) begin
                w_best_i = IDX_W'(k);
                w_best_d = r_acc[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_acc && r_state == S_LOAD) r_cent[r_kcnt][r_dcnt] <= bus.IN_DATA;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_LOAD;
            r_dcnt  <= '0;
            r_kcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_acc) begin
                r_state <= bus.IN_LAST ? S_LOAD : (r_state == S_POINT || (w_dlast && w_kend)) ? S_POINT : S_LOAD;
                r_dcnt  <= (w_dlast || bus.IN_LAST) ? '0 : r_dcnt + 1'b1;
                r_kcnt  <= (bus.IN_LAST || r_state == S_POINT || (w_dlast && w_kend)) ? '0
                         : w_dlast ? r_kcnt + 1'b1 : r_kcnt;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s0_v     <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s1_v     <= 1'b0;
            r_out_v    <= 1'b0;
            r_out_idx  <= '0;
            r_out_dist <= '0;
            for (int k = 0; k < K; k++) begin
                r_diff[k] <= '0;
                r_acc[k]  <= '0;
            end
        end else if (!w_stall) begin
            r_s0_v <= w_acc && r_state == S_POINT;
            if (w_acc) begin
                r_s0_first <= r_dcnt == '0;
                r_s0_last  <= w_dlast;
                for (int k = 0; k < K; k++) r_diff[k] <= w_diff[k];
            end
            r_s1_v <= r_s0_v && r_s0_last;
            if (r_s0_v) begin
                for (int k = 0; k < K; k++) r_acc[k] <= (r_s0_first ? '0 : r_acc[k]) + DIST_W'(w_sq[k]);
            end
            r_out_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_idx  <= w_best_i;
                r_out_dist <= w_best_d;
            end
        end
    end
endmodule

// File: tb/tb_kmeans_assign_param.sv
// tb_kmeans_assign_param: directed plus randomized checks of the K=3, DIM=2, DW=32 assignment engine.
module tb_kmeans_assign_param;
    typedef struct {
        logic [1:0]  i;
        logic [65:0] d;
    } res_t;

    logic        CLK;
    logic        RESET;
    int          tests = 0;
    int          fails = 0;
    int          err_cnt = 0;
    int          rdy_mode = 0;
    logic [31:0] cent [3][2];
    res_t        q [$];

    kmeans_assign_param_if #(.DW(32), .IDX_W(2), .DIST_W(65)) bus ();
    kmeans_assign_param #(.K(3), .DIM(2), .DW(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: brute-force nearest centroid by squared distance, first minimum wins.
    function automatic res_t model(input logic [31:0] x0, input logic [31:0] x1);
        res_t        r;
        logic [31:0] x [2];
        logic [65:0] d, df;
        x[0] = x0;
        x[1] = x1;
        r.i  = '0;
        r.d  = '1;
        for (int k = 0; k < 3; k++) begin
            d = '0;
            for (int j = 0; j < 2; j++) begin
                df = x[j] >= cent[k][j] ? x[j] - cent[k][j] : cent[k][j] - x[j];
                d  = d + df * df;
            end
            if (k == 0 || d < r.d) begin
                r.i = 2'(k);
                r.d = d;
            end
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        bus.OUT_READY = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
    end

    always begin
        res_t r;
        @(negedge CLK);
        #2;
        if (!RESET) begin
            if (bus.ERR) err_cnt++;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                chk("out_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    r = q.pop_front();
                    chk("out_idx", bus.OUT_DATA, r.i);
                    chk("out_dist", bus.OUT_DIST, r.d);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge CLK);
        #1;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        bus.IN_LAST  = l;
        while (!bus.IN_READY && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", n, 0);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a0, a1, b0, b1, c0, c1);
        send(a0, 0); send(a1, 0); send(b0, 0); send(b1, 0); send(c0, 0); send(c1, 0);
        cent[0][0] = a0; cent[0][1] = a1;
        cent[1][0] = b0; cent[1][1] = b1;
        cent[2][0] = c0; cent[2][1] = c1;
    endtask

    task automatic send_point(input logic [31:0] x0, x1, input logic l);
        send(x0, 0);
        send(x1, l);
        q.push_back(model(x0, x1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA = '0;
        bus.IN_LAST = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_in_ready", bus.IN_READY, 0);
        chk("rst_out_valid", bus.OUT_VALID, 0);
        chk("rst_out_data", bus.OUT_DATA, 0);
        chk("rst_out_dist", bus.OUT_DIST, 0);
        chk("rst_err", bus.ERR, 0);
        RESET = 1'b0;
        #1;
        chk("rel_in_ready", bus.IN_READY, 1);

        load(10, 10, 100, 100, 1000, 1000);
        send_point(12, 9, 0);
        chk("lat_n0", bus.OUT_VALID, 0);
        @(posedge CLK); #1;
        chk("lat_n1", bus.OUT_VALID, 0);
        @(posedge CLK); #1;
        chk("lat_n2", bus.OUT_VALID, 1);
        chk("p12_9_idx", bus.OUT_DATA, 0);
        chk("p12_9_dist", bus.OUT_DIST, 5);

        send_point(55, 55, 1);
        repeat (2) @(posedge CLK);
        #1;
        chk("tie_idx", bus.OUT_DATA, 0);
        chk("tie_dist", bus.OUT_DIST, 4050);
        drain("drain_tie");

        load(0, 0, 0, 0, 0, 0);
        send_point(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        repeat (2) @(posedge CLK);
        #1;
        chk("max_idx", bus.OUT_DATA, 0);
        chk("max_dist", bus.OUT_DIST, 65'h1_FFFF_FFFC_0000_0002);
        drain("drain_max");

        load(10, 10, 100, 100, 1000, 1000);
        rdy_mode = 2;
        fork
            begin
                send_point(12, 9, 0);
                send_point(99, 101, 0);
                send_point(900, 1100, 0);
            end
            begin
                repeat (5) @(negedge CLK);
                #1;
                chk("stall_in_ready", bus.IN_READY, 0);
                chk("stall_out_valid", bus.OUT_VALID, 1);
                rdy_mode = 0;
            end
        join
        drain("drain_stall");

        send(7, 1);
        chk("err_pulse", bus.ERR, 1);
        @(posedge CLK); #1;
        chk("err_clear", bus.ERR, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("err_no_out", bus.OUT_VALID, 0);
        chk("err_count", err_cnt, 1);
        load(5, 0, 0, 5, 50, 50);
        send_point(1, 4, 1);
        repeat (2) @(posedge CLK);
        #1;
        chk("after_err_idx", bus.OUT_DATA, 1);
        chk("after_err_dist", bus.OUT_DIST, 2);
        drain("drain_err");

        load(1, 2, 3, 4, 5, 6);
        send(3, 0);
        send(4, 0);
        RESET = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.IN_READY, 0);
        chk("mid_rst_out_data", bus.OUT_DATA, 0);
        chk("mid_rst_out_dist", bus.OUT_DIST, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("mid_rst_no_out", bus.OUT_VALID, 0);
        load(20, 20, 40, 40, 60, 60);
        send_point(58, 61, 1);
        repeat (2) @(posedge CLK);
        #1;
        chk("post_rst_idx", bus.OUT_DATA, 2);
        chk("post_rst_dist", bus.OUT_DIST, 5);
        drain("drain_rst");

        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            logic [31:0] c [6];
            for (int j = 0; j < 6; j++) c[j] = f == 1 ? $urandom : 32'($urandom_range(0, 15));
            load(c[0], c[1], c[2], c[3], c[4], c[5]);
            for (int p = 0; p < 8; p++) begin
                logic [31:0] x0, x1;
                x0 = f == 1 ? $urandom : 32'($urandom_range(0, 15));
                x1 = f == 1 ? $urandom : 32'($urandom_range(0, 15));
                send_point(x0, x1, p == 7);
            end
        end
        rdy_mode = 0;
        drain("drain_rand");
        chk("err_total", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
